// File: rtl/vip_stream_pkg.sv
// Shared definitions for the VIP pixel stream blocks.
// Holds the controller state encoding, default geometry and pixel widths,
// and the packed pixel layout {R[23:16], G[15:8], B[7:0]}.
package vip_stream_pkg;

  localparam int DWIDTH_DEF = 24;
  localparam int DIMW_DEF   = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

endpackage

// File: rtl/fifo_video_streamer_if.sv
// Bundle of geometry config, FIFO read port and pixel stream signals for
// fifo_video_streamer.
//   master : streamer side (drives fifo_rdreq, out_*, frame_done, cfg_error, busy)
//   slave  : environment side (drives width/height/cfg_valid, FIFO flags/data, out_ready)
// Optional macro STREAMER_UNDERFLOW_CNT_EN adds the 16-bit underflow_cnt output.
interface fifo_video_streamer_if
  import vip_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DIMW   = DIMW_DEF
);
  logic [DIMW-1:0]   width;
  logic [DIMW-1:0]   height;
  logic              cfg_valid;
  logic              fifo_empty;
  logic [DWIDTH-1:0] fifo_q;
  logic              fifo_rdreq;
  logic [DWIDTH-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eol;
  logic              out_eof;
  logic              frame_done;
  logic              cfg_error;
  logic              busy;
`ifdef STREAMER_UNDERFLOW_CNT_EN
  logic [15:0]       underflow_cnt;
`endif

  modport master (
    input  width, height, cfg_valid, fifo_empty, fifo_q, out_ready,
    output fifo_rdreq, out_data, out_valid, out_sof, out_eol, out_eof,
           frame_done, cfg_error, busy
`ifdef STREAMER_UNDERFLOW_CNT_EN
    , output underflow_cnt
`endif
  );

  modport slave (
    output width, height, cfg_valid, fifo_empty, fifo_q, out_ready,
    input  fifo_rdreq, out_data, out_valid, out_sof, out_eol, out_eof,
           frame_done, cfg_error, busy
`ifdef STREAMER_UNDERFLOW_CNT_EN
    , input underflow_cnt
`endif
  );

endinterface

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO used as the output stage of the pixel streamer.
// Ports: clock/reset (async, active-high); push/push_data write an entry;
// pop removes the head; out_valid/out_data present the head; count is the
// current occupancy (0..2). The writer must never push into a full buffer.
module stream_skid_buf
  import vip_stream_pkg::*;
#(
  parameter int W = DWIDTH_DEF + 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic [1:0]   count
);
  logic [W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]   count_q, count_d;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Simultaneous push/pop: the new word lands behind whatever remains.
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign count     = count_q;

endmodule

// File: rtl/fifo_video_streamer.sv
// Drains a non-showahead RGB pixel FIFO and emits a valid/ready pixel stream
// with sof/eol/eof markers for a width x height frame.
// Ports: clock, reset (async, active-high); bus (fifo_video_streamer_if.master)
// carrying geometry config, FIFO read port, output stream, frame_done,
// cfg_error and busy.
// Optional macro STREAMER_UNDERFLOW_CNT_EN adds a saturating 16-bit count of
// RUN cycles where the sink was ready but no pixel was available.
module fifo_video_streamer
  import vip_stream_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DIMW   = DIMW_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  fifo_video_streamer_if.master bus
);
  localparam int PW = DWIDTH + 3;

  logic [1:0]        state_q, state_d;
  logic [DIMW-1:0]   width_q, width_d, height_q, height_d;
  logic [DIMW-1:0]   wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic [2*DIMW-1:0] issued_q, issued_d, frame_px;
  logic              cfg_error_q, cfg_error_d, rd_pend_q;
  logic [1:0]        buf_count, occ_net;
  logic              buf_valid, pop, rdreq, enter_run;
  logic              push_sof, push_eol, push_eof;
  logic [PW-1:0]     buf_data;

  assign frame_px = {{DIMW{1'b0}}, width_q} * {{DIMW{1'b0}}, height_q};
  assign pop      = buf_valid & bus.out_ready;
  // Occupancy net of this cycle's pop plus the word already in flight; this
  // keeps the buffer from overflowing while still allowing one read per cycle.
  assign occ_net  = buf_count - {1'b0, pop} + {1'b0, rd_pend_q};
  assign rdreq    = (state_q == ST_RUN) && !bus.fifo_empty &&
                    (occ_net < 2'd2) && (issued_q < frame_px);
  assign enter_run = (state_q == ST_IDLE) && bus.cfg_valid &&
                     (bus.width != '0) && (bus.height != '0);

  // Markers are computed for the word entering the buffer, from the position
  // of the next pixel to be written, and travel with it as registered fields.
  assign push_sof = (wr_x_q == '0) && (wr_y_q == '0);
  assign push_eol = (wr_x_q == width_q - DIMW'(1));
  assign push_eof = push_eol && (wr_y_q == height_q - DIMW'(1));

  stream_skid_buf #(.W(PW)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (rd_pend_q),
    .push_data ({bus.fifo_q, push_sof, push_eol, push_eof}),
    .pop       (pop),
    .out_valid (buf_valid),
    .out_data  (buf_data),
    .count     (buf_count)
  );

  always_comb begin
    state_d     = state_q;
    width_d     = width_q;
    height_d    = height_q;
    cfg_error_d = cfg_error_q;
    issued_d    = issued_q;
    wr_x_d      = wr_x_q;
    wr_y_d      = wr_y_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.cfg_valid) begin
          width_d     = bus.width;
          height_d    = bus.height;
          cfg_error_d = !enter_run;
        end
        if (enter_run) begin
          state_d  = ST_RUN;
          issued_d = '0;
          wr_x_d   = '0;
          wr_y_d   = '0;
        end
      end
      ST_RUN: begin
        if (rdreq) issued_d = issued_q + (2*DIMW)'(1);
        if (rd_pend_q) begin
          if (push_eof) begin
            wr_x_d = '0;
            wr_y_d = '0;
          end else if (push_eol) begin
            wr_x_d = '0;
            wr_y_d = wr_y_q + DIMW'(1);
          end else begin
            wr_x_d = wr_x_q + DIMW'(1);
          end
        end
        if (pop && buf_data[0]) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      width_q     <= '0;
      height_q    <= '0;
      cfg_error_q <= 1'b0;
      issued_q    <= '0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      cfg_error_q <= cfg_error_d;
      issued_q    <= issued_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      rd_pend_q   <= rdreq;
    end
  end

  assign bus.fifo_rdreq = rdreq;
  assign bus.out_valid  = buf_valid;
  assign bus.out_data   = buf_data[PW-1:3];
  assign bus.out_sof    = buf_valid & buf_data[2];
  assign bus.out_eol    = buf_valid & buf_data[1];
  assign bus.out_eof    = buf_valid & buf_data[0];
  assign bus.frame_done = (state_q == ST_DONE);
  assign bus.cfg_error  = cfg_error_q;
  assign bus.busy       = (state_q != ST_IDLE);

`ifdef STREAMER_UNDERFLOW_CNT_EN
  logic [15:0] underflow_cnt_q, underflow_cnt_d;

  always_comb begin
    underflow_cnt_d = underflow_cnt_q;
    if (enter_run)
      underflow_cnt_d = '0;
    else if ((state_q == ST_RUN) && bus.out_ready && !buf_valid &&
             (underflow_cnt_q != 16'hFFFF))
      underflow_cnt_d = underflow_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) underflow_cnt_q <= '0;
    else       underflow_cnt_q <= underflow_cnt_d;
  end

  assign bus.underflow_cnt = underflow_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_video_streamer.sv
// Directed testbench for fifo_video_streamer with a behavioural
// non-showahead FIFO model feeding the streamer.
module tb_fifo_video_streamer;
  import vip_stream_pkg::*;

  localparam int DW = 24;
  localparam int DM = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_video_streamer_if #(.DWIDTH(DW), .DIMW(DM)) bus ();

  fifo_video_streamer #(.DWIDTH(DW), .DIMW(DM)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  // Source FIFO model: data appears on fifo_q the cycle after a read request.
  logic [DW-1:0] mem [0:127];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            rd_total = 0;
  logic          flush = 1'b0;
  logic [DW-1:0] fq = '0;

  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  assign bus.fifo_q     = fq;

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rdreq) begin
      fq       <= mem[rd_ptr];
      rd_ptr   <= rd_ptr + 1;
      rd_total <= rd_total + 1;
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          nb;
  int          done_t;
  int          r0;
  logic [26:0] beats [0:63];
  int          beat_t [0:63];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_px(input logic [DW-1:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
  endtask

  task automatic start_cfg(input int w, input int h);
    bus.width     = DM'(w);
    bus.height    = DM'(h);
    bus.cfg_valid = 1'b1;
    cyc();
    bus.cfg_valid = 1'b0;
  endtask

  // Drives out_ready from a 4-cycle pattern and records every handshake.
  // Stops on frame_done, or after stop_n beats when stop_n > 0.
  task automatic run_frame(input logic [3:0] rpat, input int stop_n,
                           input int inj_t, input int inj_n, input logic [DW-1:0] inj_base);
    logic        stall = 1'b0;
    logic [26:0] prev = '0;
    logic [26:0] cur;
    nb = 0;
    done_t = -1;
    for (int t = 0; t < 200; t++) begin
      if (t == inj_t)
        for (int k = 0; k < inj_n; k++) push_px(inj_base + DW'(k));
      bus.out_ready = rpat[t % 4];
      cur = {bus.out_data, bus.out_sof, bus.out_eol, bus.out_eof};
      if (stall) begin
        chk($sformatf("stall_valid_t%0d", t), {31'd0, bus.out_valid}, 32'd1);
        chk($sformatf("stall_hold_t%0d", t), {5'd0, cur}, {5'd0, prev});
      end
      stall = bus.out_valid && !bus.out_ready;
      prev  = cur;
      if (bus.out_valid && bus.out_ready) begin
        beats[nb]  = cur;
        beat_t[nb] = t;
        nb++;
      end
      if (bus.frame_done) begin
        done_t = t;
        cyc();
        chk("done_one_cycle", {31'd0, bus.frame_done}, 32'd0);
        chk("idle_after_done", {31'd0, bus.busy}, 32'd0);
        break;
      end
      if (stop_n > 0 && nb == stop_n) begin
        cyc();
        break;
      end
      cyc();
    end
    if (stop_n == 0 && done_t < 0) begin
      checks++;
      failures++;
      $error("FAIL frame_timeout observed=no_frame_done expected=frame_done beats=%0d", nb);
    end
  endtask

  task automatic verify(input string tag, input int w, input int h, input logic [DW-1:0] base);
    logic sof, eol, eof;
    chk({tag, "_beat_count"}, nb, w * h);
    for (int i = 0; i < nb; i++) begin
      sof = (i == 0);
      eol = ((i % w) == w - 1);
      eof = eol && ((i / w) == h - 1);
      chk($sformatf("%s_beat%0d", tag, i), {5'd0, beats[i]},
          {5'd0, base + DW'(i), sof, eol, eof});
    end
    if (nb > 0) chk({tag, "_done_latency"}, done_t - beat_t[nb-1], 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.width     = '0;
    bus.height    = '0;
    bus.cfg_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) cyc();

    // Reset state
    chk("rst_valid",  {31'd0, bus.out_valid},  32'd0);
    chk("rst_rdreq",  {31'd0, bus.fifo_rdreq}, 32'd0);
    chk("rst_busy",   {31'd0, bus.busy},       32'd0);
    chk("rst_cfgerr", {31'd0, bus.cfg_error},  32'd0);
    chk("rst_done",   {31'd0, bus.frame_done}, 32'd0);
    chk("rst_sof",    {31'd0, bus.out_sof},    32'd0);
    rst = 1'b0;
    cyc();

    // 4x2 frame, sink always ready
    for (int i = 1; i <= 8; i++) push_px(DW'(i));
    bus.out_ready = 1'b1;
    r0 = rd_total;
    start_cfg(4, 2);
    chk("t1_rdreq_first", {31'd0, bus.fifo_rdreq}, 32'd1);
    chk("t1_busy", {31'd0, bus.busy}, 32'd1);
    run_frame(4'b1111, 0, -1, 0, '0);
    verify("t1", 4, 2, 24'h000001);
    chk("t1_first_latency", beat_t[0], 2);
    chk("t1_back_to_back", beat_t[7] - beat_t[0], 7);
    chk("t1_rdreq_count", rd_total - r0, 8);
`ifdef STREAMER_UNDERFLOW_CNT_EN
    chk("t1_underflow_cnt", {16'd0, bus.underflow_cnt}, 32'd2);
`endif

    // Same frame, sink ready pattern 1,0,0,1
    for (int i = 1; i <= 8; i++) push_px(DW'(i));
    r0 = rd_total;
    start_cfg(4, 2);
    run_frame(4'b1001, 0, -1, 0, '0);
    verify("t2", 4, 2, 24'h000001);
    chk("t2_rdreq_count", rd_total - r0, 8);

    // FIFO underrun mid-line: 3 pixels, 5 more arrive later
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) push_px(24'h000021 + DW'(i));
    start_cfg(4, 2);
    run_frame(4'b1111, 0, 10, 5, 24'h000024);
    verify("t3", 4, 2, 24'h000021);
    chk("t3_gap_after_px3", {31'd0, (beat_t[3] - beat_t[2]) > 1}, 32'd1);

    // 1x1 frame: one beat with all markers, surplus words stay in the FIFO
    push_px(24'hABCDEF);
    for (int k = 0; k < 12; k++) push_px(24'h000100 + DW'(k));
    r0 = rd_total;
    start_cfg(1, 1);
    run_frame(4'b1111, 0, -1, 0, '0);
    verify("t4", 1, 1, 24'hABCDEF);
    chk("t4_rdreq_count", rd_total - r0, 1);
    chk("t4_words_left", wr_ptr - rd_ptr, 12);
    flush = 1'b1;
    cyc();
    flush = 1'b0;

    // Zero width is rejected, then a valid 2x2 clears the error
    for (int i = 0; i < 4; i++) push_px(24'h000031 + DW'(i));
    r0 = rd_total;
    start_cfg(0, 2);
    chk("t5_cfg_error", {31'd0, bus.cfg_error}, 32'd1);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_rdreq", {31'd0, bus.fifo_rdreq}, 32'd0);
    repeat (4) cyc();
    chk("t5_no_reads", rd_total - r0, 0);
    chk("t5_error_sticky", {31'd0, bus.cfg_error}, 32'd1);
    start_cfg(2, 2);
    chk("t5_error_cleared", {31'd0, bus.cfg_error}, 32'd0);
    chk("t5_busy_run", {31'd0, bus.busy}, 32'd1);
    run_frame(4'b1111, 0, -1, 0, '0);
    verify("t5", 2, 2, 24'h000031);

    // Reset after 3 beats, then a fresh frame restarts at sof
    for (int i = 0; i < 8; i++) push_px(24'h000041 + DW'(i));
    start_cfg(4, 2);
    run_frame(4'b1111, 3, -1, 0, '0);
    chk("t6_partial_beats", nb, 3);
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", {31'd0, bus.out_valid},  32'd0);
    chk("t6_rst_data",  {8'd0, bus.out_data},    32'd0);
    chk("t6_rst_sof",   {31'd0, bus.out_sof},    32'd0);
    chk("t6_rst_eol",   {31'd0, bus.out_eol},    32'd0);
    chk("t6_rst_eof",   {31'd0, bus.out_eof},    32'd0);
    chk("t6_rst_rdreq", {31'd0, bus.fifo_rdreq}, 32'd0);
    chk("t6_rst_busy",  {31'd0, bus.busy},       32'd0);
    chk("t6_rst_done",  {31'd0, bus.frame_done}, 32'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) push_px(24'h000051 + DW'(i));
    start_cfg(4, 2);
    run_frame(4'b1111, 0, -1, 0, '0);
    verify("t6", 4, 2, 24'h000051);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_video_streamer.md
Name: fifo_video_streamer

Overview:
- Downstream neighbour of the testbench image generator.
- Drains the RGB pixel FIFO through a registered read port and emits a valid/ready pixel stream with frame and line markers (sof/eol/eof).
- Frame geometry comes from the generator's width/height outputs.
- Used in TB and synthesizable paths ahead of VIP processing cores.

Parameters:
- DWIDTH, 24, pixel width (packed {R,G,B}, 8 bits each at default).
- DIMW, 11, width of width/height/counters.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- width  in  DIMW  pixels per line, sampled on cfg_valid
- height  in  DIMW  lines per frame, sampled on cfg_valid
- cfg_valid  in  1  geometry valid; latched only in IDLE
- fifo_empty  in  1  FIFO empty flag
- fifo_q  in  DWIDTH  FIFO read data, valid 1 cycle after fifo_rdreq (non-showahead)
- fifo_rdreq  out  1  FIFO read request
- out_data  out  DWIDTH  pixel
- out_valid  out  1  pixel valid
- out_ready  in  1  sink accepts
- out_sof  out  1  first pixel of frame
- out_eol  out  1  last pixel of line
- out_eof  out  1  last pixel of frame
- frame_done  out  1  one-cycle pulse after eof handshake
- cfg_error  out  1  sticky; zero width or height latched
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0. State IDLE. Counters and buffer cleared. In-flight read discarded.
- States:
  - IDLE: when cfg_valid=1, latch width/height. If either is 0, set cfg_error and stay in IDLE. Otherwise clear cfg_error and go to RUN.
  - RUN: on the eof handshake go to DONE.
  - DONE: one cycle; frame_done=1; go to IDLE.
- Output buffer: 2-entry register FIFO (skid).
- Read issue:
  - fifo_rdreq = RUN && !fifo_empty && (occupancy + inflight < 2) && (issued < width*height).
  - issued is a 2*DIMW-bit counter, cleared on entering RUN.
  - Never read beyond the frame; surplus FIFO words remain for the next frame.
- Latency: rdreq in cycle N -> fifo_q captured at the end of N+1 -> out_valid high in N+2 (when the buffer was empty).
- Handshake:
  - Transfer occurs when out_valid && out_ready.
  - While out_ready=0, out_data and all markers hold stable and out_valid stays 1.
  - out_valid never drops without a transfer.
- Sustained throughput: 1 pixel/cycle when FIFO non-empty and out_ready=1.
- Position counters x, y (DIMW bits) advance only on transfer:
  - x wraps to 0 at width-1, and y then increments.
  - Both clear after eof.
- Markers (registered buffer fields, not combinational from inputs):
  - out_sof = (x==0 && y==0)
  - out_eol = (x==width-1)
  - out_eof = out_eol && (y==height-1)
- width=1 and height=1: a single beat carries sof, eol and eof together.
- FIFO empty mid-line: out_valid deasserts after the buffer drains. Counters hold. Resumes without marker corruption.
- cfg_valid in RUN or DONE is ignored.
- Reset mid-frame: immediate return to IDLE. A partial frame is never completed. Next frame restarts with sof.

Optional Feature:
- STREAMER_UNDERFLOW_CNT_EN.
  - Defined: adds output underflow_cnt [15:0], saturating. Increments each RUN cycle with out_ready=1 && out_valid=0. Cleared on reset and on entering RUN.
  - Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package vip_stream_pkg holds:
  - state encoding constants ST_IDLE=0, ST_RUN=1, ST_DONE=2;
  - the DIMW default;
  - the pixel struct layout {R[23:16],G[15:8],B[7:0]}.
- Sub-module stream_skid_buf (2-entry register FIFO with valid/ready, parameterized width).
  - Carries {data, sof, eol, eof}, width DWIDTH+3.

Test Plan:
- width=4, height=2, FIFO preloaded with 8 pixels 0x000001..0x000008, out_ready=1 -> 8 consecutive beats:
  - sof on beat 1;
  - eol on beats 4 and 8;
  - eof on beat 8;
  - frame_done pulse 1 cycle later;
  - fifo_rdreq asserted exactly 8 times.
- Same frame with out_ready toggling 1,0,0,1 -> identical data/marker sequence; data held stable across stalls; no lost or duplicated pixel.
- FIFO holds 3 pixels, 5 more written 10 cycles later -> out_valid gap after pixel 3; pixel 4 carries no sof; eol at pixel 4 and pixel 8 correct.
- width=1, height=1, one pixel 0xABCDEF -> single beat with sof=eol=eof=1; 12 extra FIFO words not read.
- cfg_valid with width=0 -> cfg_error=1, busy=0, fifo_rdreq never asserted. Valid cfg (2x2) then clears cfg_error and runs.
- Reset asserted after 3 of 8 beats, then reconfigured -> outputs 0 during reset; next beat carries sof; position counters restart at 0,0.
